// File: rtl/lrwait_mnode_if.sv
// Request/response and memory-bank bundle of the LRwait memory node.
// The slave modport is the node's view; master is the requester-and-bank side.
interface lrwait_mnode_if #(
   parameter int MetaWidth = 8
);
   logic [31:0]          in_qaddr_i;
   logic                 in_qwrite_i;
   logic [3:0]           in_qamo_i;
   logic [31:0]          in_qdata_i;
   logic [3:0]           in_qstrb_i;
   logic [MetaWidth-1:0] in_qmeta_i;
   logic                 in_qlrwait_i;
   logic                 in_qvalid_i;
   logic                 in_qready_o;

   logic [31:0]          in_pdata_o;
   logic                 in_perror_o;
   logic [MetaWidth-1:0] in_pmeta_o;
   logic                 in_plrwait_o;
   logic                 in_pvalid_o;
   logic                 in_pready_i;

   logic                 bank_req_o;
   logic                 bank_we_o;
   logic [31:0]          bank_addr_o;
   logic [31:0]          bank_wdata_o;
   logic [3:0]           bank_be_o;
   logic [31:0]          bank_rdata_i;

   modport slave (
      input  in_qaddr_i, in_qwrite_i, in_qamo_i, in_qdata_i, in_qstrb_i,
             in_qmeta_i, in_qlrwait_i, in_qvalid_i,
      output in_qready_o,
      output in_pdata_o, in_perror_o, in_pmeta_o, in_plrwait_o, in_pvalid_o,
      input  in_pready_i,
      output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
      input  bank_rdata_i
   );

   modport master (
      output in_qaddr_i, in_qwrite_i, in_qamo_i, in_qdata_i, in_qstrb_i,
             in_qmeta_i, in_qlrwait_i, in_qvalid_i,
      input  in_qready_o,
      input  in_pdata_o, in_perror_o, in_pmeta_o, in_plrwait_o, in_pvalid_o,
      output in_pready_i,
      input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
      output bank_rdata_i
   );
endinterface

// File: rtl/lrwait_mnode.sv
// Memory node with an LR/SC reservation and an LRwait queue (head/tail of waiters).
// One request at a time: Idle accepts, Wait collects bank data, Resp holds the reply.
module lrwait_mnode #(
   parameter int MetaWidth    = 8,
   parameter bit LrWaitEnable = 1'b1
) (
   input logic          clk_i,
   input logic          rst_i,
   lrwait_mnode_if.slave bus
);
   localparam logic [3:0] AmoNone = 4'h0;
   localparam logic [3:0] AmoLr   = 4'hA;
   localparam logic [3:0] AmoSc   = 4'hB;

   typedef enum logic [1:0] {Idle, Wait, Resp} state_e;

   state_e               state_q, state_d;
   logic                 res_valid_q, res_valid_d;
   logic [31:0]          res_addr_q, res_addr_d;
   logic [MetaWidth-1:0] head_q, head_d;
   logic [MetaWidth-1:0] tail_q, tail_d;
   logic                 head_done_q, head_done_d;
   logic [31:0]          pdata_q, pdata_d;
   logic                 perror_q, perror_d;
   logic [MetaWidth-1:0] pmeta_q, pmeta_d;
   logic                 plrwait_q, plrwait_d;
   logic                 wait_we_q, wait_we_d;

   logic                 bank_req;
   logic                 bank_we;
   logic                 res_match;
   logic                 is_head;
   logic [MetaWidth-1:0] wake_meta;
   logic [31:0]          qmeta_ext;

   assign res_match = res_valid_q && (bus.in_qaddr_i == res_addr_q);
   assign is_head   = (bus.in_qmeta_i == head_q);
   assign wake_meta = bus.in_qdata_i[MetaWidth-1:0];

   always_comb begin
      qmeta_ext = '0;
      qmeta_ext[MetaWidth-1:0] = bus.in_qmeta_i;
   end

   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q;
      res_addr_d  = res_addr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      head_done_d = head_done_q;
      pdata_d     = pdata_q;
      perror_d    = perror_q;
      pmeta_d     = pmeta_q;
      plrwait_d   = plrwait_q;
      wait_we_d   = wait_we_q;
      bank_req    = 1'b0;
      bank_we     = 1'b0;

      unique case (state_q)
         Idle: begin
            if (bus.in_qvalid_i) begin
               pdata_d   = '0;
               perror_d  = 1'b0;
               pmeta_d   = bus.in_qmeta_i;
               plrwait_d = 1'b0;

               if (bus.in_qlrwait_i) begin
                  // A wake-up passes the reservation to the successor named in the data field.
                  pmeta_d = wake_meta;
                  if (LrWaitEnable && res_match) begin
                     head_d      = wake_meta;
                     head_done_d = 1'b0;
                     bank_req    = 1'b1;
                  end else begin
                     perror_d = 1'b1;
                  end
               end else if (bus.in_qamo_i == AmoLr) begin
                  if (!LrWaitEnable) begin
                     bank_req = 1'b1;
                  end else if (!res_valid_q) begin
                     res_valid_d = 1'b1;
                     res_addr_d  = bus.in_qaddr_i;
                     head_d      = bus.in_qmeta_i;
                     tail_d      = bus.in_qmeta_i;
                     head_done_d = 1'b0;
                     bank_req    = 1'b1;
                  end else if (res_match) begin
                     if (is_head) begin
                        bank_req = 1'b1;
                     end else begin
                        // Enqueue: tell the old tail who its successor is.
                        tail_d    = bus.in_qmeta_i;
                        pmeta_d   = tail_q;
                        plrwait_d = 1'b1;
                        pdata_d   = qmeta_ext;
                     end
                  end else begin
                     perror_d = 1'b1;
                  end
               end else if (bus.in_qamo_i == AmoSc) begin
                  if (!LrWaitEnable) begin
                     bank_req = 1'b1;
                     bank_we  = 1'b1;
                  end else if (res_match && is_head && !head_done_q) begin
                     bank_req = 1'b1;
                     bank_we  = 1'b1;
                     if (head_q == tail_q) begin
                        res_valid_d = 1'b0;
                     end else begin
                        head_done_d = 1'b1;
                     end
                  end else begin
                     pdata_d = 32'd1;
                  end
               end else if (bus.in_qamo_i == AmoNone) begin
                  bank_req = 1'b1;
                  bank_we  = bus.in_qwrite_i;
               end else begin
                  perror_d = 1'b1;
               end

               wait_we_d = bank_we;
               state_d   = bank_req ? Wait : Resp;
            end
         end
         Wait: begin
            pdata_d = wait_we_q ? 32'd0 : bus.bank_rdata_i;
            state_d = Resp;
         end
         Resp: begin
            if (bus.in_pready_i) begin
               state_d = Idle;
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= Idle;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         head_done_q <= 1'b0;
         pdata_q     <= '0;
         perror_q    <= 1'b0;
         pmeta_q     <= '0;
         plrwait_q   <= 1'b0;
         wait_we_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         res_addr_q  <= res_addr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         head_done_q <= head_done_d;
         pdata_q     <= pdata_d;
         perror_q    <= perror_d;
         pmeta_q     <= pmeta_d;
         plrwait_q   <= plrwait_d;
         wait_we_q   <= wait_we_d;
      end
   end

   // The bank strobe is combinational from the Idle handshake, so it is masked during reset.
   assign bus.in_qready_o  = (state_q == Idle) && !rst_i;
   assign bus.bank_req_o   = bank_req && !rst_i;
   assign bus.bank_we_o    = bus.bank_req_o && bank_we;
   assign bus.bank_addr_o  = bus.bank_req_o ? bus.in_qaddr_i : 32'd0;
   assign bus.bank_wdata_o = bus.bank_we_o ? bus.in_qdata_i : 32'd0;
   assign bus.bank_be_o    = bus.bank_req_o ? (bank_we ? bus.in_qstrb_i : 4'hF) : 4'h0;

   assign bus.in_pvalid_o  = (state_q == Resp);
   assign bus.in_pdata_o   = pdata_q;
   assign bus.in_perror_o  = perror_q;
   assign bus.in_pmeta_o   = pmeta_q;
   assign bus.in_plrwait_o = plrwait_q;
endmodule

// File: tb/tb_lrwait_mnode.sv
// Directed bench for lrwait_mnode: a vector table of LR/SC/LRwait transactions
// against a one-cycle bank model, plus stall and mid-operation reset sequences.
module tb_lrwait_mnode;
   localparam int MetaWidth = 8;

   logic clk_i = 1'b0;
   logic rst_i;

   lrwait_mnode_if #(.MetaWidth(MetaWidth)) bus ();

   lrwait_mnode #(
      .MetaWidth   (MetaWidth),
      .LrWaitEnable(1'b1)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] mem [0:1023];
   int          bankReads;
   int          bankWrites;
   logic [31:0] lastWData;

   // Bank model: read data appears one cycle after the request; reset reloads the image.
   always @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
         mem[10'h040]     <= 32'h0000_0055;
         mem[10'h080]     <= 32'h0000_1234;
         bus.bank_rdata_i <= 32'd0;
      end else if (bus.bank_req_o) begin
         if (bus.bank_we_o) begin
            bankWrites <= bankWrites + 1;
            lastWData  <= bus.bank_wdata_o;
            for (int b = 0; b < 4; b++) begin
               if (bus.bank_be_o[b]) mem[bus.bank_addr_o[11:2]][b*8 +: 8] <= bus.bank_wdata_o[b*8 +: 8];
            end
         end else begin
            bankReads        <= bankReads + 1;
            bus.bank_rdata_i <= mem[bus.bank_addr_o[11:2]];
         end
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  amo;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [7:0]  meta;
      logic        lrwait;
      logic [31:0] expData;
      logic        expErr;
      logic [7:0]  expMeta;
      logic        expLrwait;
      int          expLat;
      int          expBank;
      logic [31:0] expWData;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic [31:0] addr, input logic write, input logic [3:0] amo,
                               input logic [31:0] data, input logic [3:0] strb, input logic [7:0] meta,
                               input logic lrwait, input logic [31:0] expData, input logic expErr,
                               input logic [7:0] expMeta, input logic expLrwait, input int expBank);
      vec_t v;
      v.addr = addr;       v.write = write;       v.amo = amo;
      v.data = data;       v.strb = strb;         v.meta = meta;
      v.lrwait = lrwait;   v.expData = expData;   v.expErr = expErr;
      v.expMeta = expMeta; v.expLrwait = expLrwait;
      v.expBank = expBank;
      v.expLat = (expBank != 0) ? 2 : 1;
      v.expWData = (expBank == 2) ? data : 32'd0;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int holdCycles, input string tag);
      int lat;
      int r0;
      int w0;
      for (int i = 0; i < 20 && !bus.in_qready_o; i++) @(negedge clk_i);
      checkOutput({tag, "_qready"}, 32'(bus.in_qready_o), 32'd1);
      bus.in_qaddr_i   = v.addr;
      bus.in_qwrite_i  = v.write;
      bus.in_qamo_i    = v.amo;
      bus.in_qdata_i   = v.data;
      bus.in_qstrb_i   = v.strb;
      bus.in_qmeta_i   = v.meta;
      bus.in_qlrwait_i = v.lrwait;
      bus.in_qvalid_i  = 1'b1;
      r0 = bankReads;
      w0 = bankWrites;
      @(posedge clk_i);
      #1;
      bus.in_qvalid_i = 1'b0;
      lat = 1;
      while (!bus.in_pvalid_o && lat < 10) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLat));
      checkOutput({tag, "_pvalid"}, 32'(bus.in_pvalid_o), 32'd1);
      checkOutput({tag, "_pdata"}, bus.in_pdata_o, v.expData);
      checkOutput({tag, "_perror"}, 32'(bus.in_perror_o), 32'(v.expErr));
      checkOutput({tag, "_pmeta"}, 32'(bus.in_pmeta_o), 32'(v.expMeta));
      checkOutput({tag, "_plrwait"}, 32'(bus.in_plrwait_o), 32'(v.expLrwait));
      checkOutput({tag, "_bankReads"}, 32'(bankReads - r0), (v.expBank == 1) ? 32'd1 : 32'd0);
      checkOutput({tag, "_bankWrites"}, 32'(bankWrites - w0), (v.expBank == 2) ? 32'd1 : 32'd0);
      if (v.expBank == 2) checkOutput({tag, "_wdata"}, lastWData, v.expWData);
      checkOutput({tag, "_qreadyBusy"}, 32'(bus.in_qready_o), 32'd0);
      for (int c = 0; c < holdCycles; c++) begin
         @(posedge clk_i);
         #1;
         checkOutput({tag, "_holdValid"}, 32'(bus.in_pvalid_o), 32'd1);
         checkOutput({tag, "_holdData"}, bus.in_pdata_o, v.expData);
         checkOutput({tag, "_holdMeta"}, 32'(bus.in_pmeta_o), 32'(v.expMeta));
         checkOutput({tag, "_holdQready"}, 32'(bus.in_qready_o), 32'd0);
      end
      bus.in_pready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.in_pready_i = 1'b0;
      checkOutput({tag, "_pvalidDone"}, 32'(bus.in_pvalid_o), 32'd0);
   endtask

   initial begin
      bankReads = 0;
      bankWrites = 0;
      lastWData = 32'd0;
      rst_i = 1'b1;
      bus.in_qaddr_i = '0;   bus.in_qwrite_i = 1'b0; bus.in_qamo_i = '0;
      bus.in_qdata_i = '0;   bus.in_qstrb_i = '0;    bus.in_qmeta_i = '0;
      bus.in_qlrwait_i = 1'b0; bus.in_qvalid_i = 1'b0; bus.in_pready_i = 1'b0;

      //                addr         wr    amo    data          strb   meta  lrw   expData       err   meta  plrw  bank
      vecs.push_back(mk(32'h100, 1'b0, 4'hA, 32'h0,        4'hF, 8'd3, 1'b0, 32'h55,       1'b0, 8'd3, 1'b0, 1));
      vecs.push_back(mk(32'h100, 1'b0, 4'hA, 32'h0,        4'hF, 8'd5, 1'b0, 32'h5,        1'b0, 8'd3, 1'b1, 0));
      vecs.push_back(mk(32'h100, 1'b1, 4'hB, 32'h77,       4'hF, 8'd3, 1'b0, 32'h0,        1'b0, 8'd3, 1'b0, 2));
      vecs.push_back(mk(32'h100, 1'b0, 4'h0, 32'h5,        4'hF, 8'd3, 1'b1, 32'h77,       1'b0, 8'd5, 1'b0, 1));
      vecs.push_back(mk(32'h100, 1'b1, 4'hB, 32'h88,       4'hF, 8'd5, 1'b0, 32'h0,        1'b0, 8'd5, 1'b0, 2));
      vecs.push_back(mk(32'h100, 1'b1, 4'hB, 32'h99,       4'hF, 8'd5, 1'b0, 32'h1,        1'b0, 8'd5, 1'b0, 0));
      vecs.push_back(mk(32'h100, 1'b0, 4'hA, 32'h0,        4'hF, 8'd6, 1'b0, 32'h88,       1'b0, 8'd6, 1'b0, 1));
      vecs.push_back(mk(32'h200, 1'b0, 4'hA, 32'h0,        4'hF, 8'd7, 1'b0, 32'h0,        1'b1, 8'd7, 1'b0, 0));
      vecs.push_back(mk(32'h200, 1'b1, 4'hB, 32'h99,       4'hF, 8'd7, 1'b0, 32'h1,        1'b0, 8'd7, 1'b0, 0));
      vecs.push_back(mk(32'h100, 1'b0, 4'hA, 32'h0,        4'hF, 8'd6, 1'b0, 32'h88,       1'b0, 8'd6, 1'b0, 1));
      vecs.push_back(mk(32'h100, 1'b1, 4'h0, 32'hAABBCCDD, 4'h3, 8'd9, 1'b0, 32'h0,        1'b0, 8'd9, 1'b0, 2));
      vecs.push_back(mk(32'h100, 1'b0, 4'h0, 32'h0,        4'hF, 8'd9, 1'b0, 32'h0000CCDD, 1'b0, 8'd9, 1'b0, 1));
      vecs.push_back(mk(32'h100, 1'b1, 4'hB, 32'h11,       4'hF, 8'd6, 1'b0, 32'h0,        1'b0, 8'd6, 1'b0, 2));
      vecs.push_back(mk(32'h100, 1'b0, 4'h3, 32'h0,        4'hF, 8'd2, 1'b0, 32'h0,        1'b1, 8'd2, 1'b0, 0));
      vecs.push_back(mk(32'h100, 1'b0, 4'h0, 32'h4,        4'hF, 8'd1, 1'b1, 32'h0,        1'b1, 8'd4, 1'b0, 0));
      vecs.push_back(mk(32'h100, 1'b0, 4'h0, 32'h0,        4'hF, 8'd9, 1'b0, 32'h11,       1'b0, 8'd9, 1'b0, 1));
      vecs.push_back(mk(32'h300, 1'b0, 4'hA, 32'h0,        4'hF, 8'd1, 1'b0, 32'h0,        1'b0, 8'd1, 1'b0, 1));
      vecs.push_back(mk(32'h300, 1'b0, 4'hA, 32'h0,        4'hF, 8'd2, 1'b0, 32'h2,        1'b0, 8'd1, 1'b1, 0));
      vecs.push_back(mk(32'h300, 1'b1, 4'hB, 32'h3A,       4'hF, 8'd2, 1'b0, 32'h1,        1'b0, 8'd2, 1'b0, 0));
      vecs.push_back(mk(32'h300, 1'b1, 4'hB, 32'h31,       4'hF, 8'd1, 1'b0, 32'h0,        1'b0, 8'd1, 1'b0, 2));
      vecs.push_back(mk(32'h300, 1'b1, 4'hB, 32'h3F,       4'hF, 8'd1, 1'b0, 32'h1,        1'b0, 8'd1, 1'b0, 0));
      vecs.push_back(mk(32'h300, 1'b0, 4'h0, 32'h2,        4'hF, 8'd0, 1'b1, 32'h31,       1'b0, 8'd2, 1'b0, 1));
      vecs.push_back(mk(32'h300, 1'b1, 4'hB, 32'h32,       4'hF, 8'd2, 1'b0, 32'h0,        1'b0, 8'd2, 1'b0, 2));
      vecs.push_back(mk(32'h300, 1'b1, 4'hB, 32'h33,       4'hF, 8'd2, 1'b0, 32'h1,        1'b0, 8'd2, 1'b0, 0));

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("rst_qready", 32'(bus.in_qready_o), 32'd0);
      checkOutput("rst_pvalid", 32'(bus.in_pvalid_o), 32'd0);
      checkOutput("rst_bankReq", 32'(bus.bank_req_o), 32'd0);
      checkOutput("rst_pdata", bus.in_pdata_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rst_qreadyAfter", 32'(bus.in_qready_o), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], 0, $sformatf("vec%0d", i));
      end

      applyStimulus(mk(32'h200, 1'b0, 4'h0, 32'h0, 4'hF, 8'd4, 1'b0, 32'h1234, 1'b0, 8'd4, 1'b0, 1), 5, "stall");

      // Reset while a bank read sits in Wait must drop both the reply and the reservation.
      applyStimulus(mk(32'h400, 1'b0, 4'hA, 32'h0, 4'hF, 8'd1, 1'b0, 32'h0, 1'b0, 8'd1, 1'b0, 1), 0, "resLr");
      @(negedge clk_i);
      bus.in_qaddr_i = 32'h100; bus.in_qwrite_i = 1'b0; bus.in_qamo_i = 4'h0;
      bus.in_qmeta_i = 8'd9;    bus.in_qlrwait_i = 1'b0; bus.in_qvalid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.in_qvalid_i = 1'b0;
      checkOutput("midrst_waitPvalid", 32'(bus.in_pvalid_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      checkOutput("midrst_qready", 32'(bus.in_qready_o), 32'd0);
      checkOutput("midrst_pvalid", 32'(bus.in_pvalid_o), 32'd0);
      checkOutput("midrst_bankReq", 32'(bus.bank_req_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("midrst_qreadyAfter", 32'(bus.in_qready_o), 32'd1);
      repeat (3) begin
         @(posedge clk_i);
         #1;
         checkOutput("midrst_noResp", 32'(bus.in_pvalid_o), 32'd0);
      end
      applyStimulus(mk(32'h400, 1'b1, 4'hB, 32'h44, 4'hF, 8'd1, 1'b0, 32'h1, 1'b0, 8'd1, 1'b0, 0), 0, "midrst_sc");
      applyStimulus(mk(32'h400, 1'b0, 4'hA, 32'h0, 4'hF, 8'd2, 1'b0, 32'h0, 1'b0, 8'd2, 1'b0, 1), 0, "midrst_lr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
